wb_find_master: RTL and testbench

Wishbone classic single-transfer master that drives the `wb_find` slave port, the initiator side of the user-area bus. It takes read, write and poll commands over a valid/ready command channel and issues one Wishbone cycle per attempt. It returns data and a status word over a valid/ready response channel. It is used in bench harnesses and in the on-chip self-test path, where it loads sequence/E registers and polls the done flag without management-SoC firmware.

---
 rtl/wb_find_master_pkg.sv | 28 ++
 rtl/wb_find_master.sv | 158 +++++++++++++++
 tb/tb_wb_find_master.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_find_master_pkg.sv
// Shared encodings for the wb_find Wishbone master.
// Ops, response status codes and FSM states.
package wb_find_master_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_TIMEOUT   = 2'b01;
    localparam logic [1:0] ST_EXHAUSTED = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_RSP
    } state_e;

    function automatic logic poll_hit(
        input logic [31:0] data,
        input logic [31:0] mask,
        input logic [31:0] match
    );
        return (data & mask) == (match & mask);
    endfunction

endpackage

// File: rtl/wb_find_master.sv
// Wishbone classic single-transfer master for the wb_find port.
// Read/write/poll commands in, data + status responses out.
import wb_find_master_pkg::*;

module wb_find_master #(
    parameter int ACK_TIMEOUT = 255,
    parameter int POLL_LIMIT  = 1023,
    parameter int POLL_GAP    = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [31:0] cmd_mask,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic [1:0]  rsp_status,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam int GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

    localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

    state_e        state;
    logic [1:0]    op_q;
    logic [31:0]   mask_q;
    logic [TW-1:0] tmo_cnt;
    logic [PW-1:0] poll_cnt;
    logic [GW-1:0] gap_cnt;

    // Command FSM; every output is a register. wbm_dat_o doubles as the
    // poll match value since a poll never writes.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state      <= S_IDLE;
            op_q       <= OP_READ;
            mask_q     <= '0;
            tmo_cnt    <= '0;
            poll_cnt   <= '0;
            gap_cnt    <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_dat    <= '0;
            rsp_status <= ST_OK;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        unique case (1'b1)
                            cmd_op == OP_WRITE: op_q <= OP_WRITE;
                            cmd_op == OP_POLL:  op_q <= OP_POLL;
                            default:            op_q <= OP_READ;
                        endcase
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_we_o  <= (cmd_op == OP_WRITE);
                        mask_q    <= cmd_mask;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cmd_ready <= 1'b0;
                        tmo_cnt   <= '0;
                        poll_cnt  <= '0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (wbm_ack_i) begin
                        tmo_cnt <= '0;
                        if (op_q != OP_POLL) begin
                            rsp_dat    <= (op_q == OP_READ) ? wbm_dat_i : '0;
                            rsp_status <= ST_OK;
                            wbm_cyc_o  <= 1'b0;
                            wbm_stb_o  <= 1'b0;
                            wbm_we_o   <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= S_RSP;
                        end else if (poll_hit(wbm_dat_i, mask_q, wbm_dat_o)) begin
                            rsp_dat    <= wbm_dat_i;
                            rsp_status <= ST_OK;
                            wbm_cyc_o  <= 1'b0;
                            wbm_stb_o  <= 1'b0;
                            rsp_valid  <= 1'b1;
                            state      <= S_RSP;
                        end else begin
                            poll_cnt <= poll_cnt + 1'b1;
                            if (poll_cnt == POLL_LAST) begin
                                rsp_dat    <= wbm_dat_i;
                                rsp_status <= ST_EXHAUSTED;
                                wbm_cyc_o  <= 1'b0;
                                wbm_stb_o  <= 1'b0;
                                rsp_valid  <= 1'b1;
                                state      <= S_RSP;
                            end else if (POLL_GAP != 0) begin
                                wbm_cyc_o <= 1'b0;
                                wbm_stb_o <= 1'b0;
                                gap_cnt   <= '0;
                                state     <= S_GAP;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        rsp_dat    <= '0;
                        rsp_status <= ST_TIMEOUT;
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        wbm_we_o   <= 1'b0;
                        rsp_valid  <= 1'b1;
                        state      <= S_RSP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= S_REQ;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_find_master.sv
// Bench for wb_find_master: scoreboard of expected responses,
// behavioural Wishbone slave and bus monitor.
import wb_find_master_pkg::*;

module tb_wb_find_master;

    localparam int AT = 8;
    localparam int PL = 4;
    localparam int PG = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [31:0] cmd_mask = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack;

    wb_find_master #(
        .ACK_TIMEOUT(AT),
        .POLL_LIMIT (PL),
        .POLL_GAP   (PG)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_mask  (cmd_mask),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_status(rsp_status),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_sel_o (sel),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack)
    );

    always #5 clk = ~clk;

    // slave model and bus monitor
    logic        slv_en = 1'b0;
    logic        slv_force = 1'b0;
    logic        slv_rst = 1'b0;
    int          slv_wait = 0;
    logic [31:0] slv_mem [8];
    int          rd_idx = 0;
    int          wcnt = 0;
    int          acks = 0;
    int          stb_cyc = 0;
    int          idle_run = 0;
    int          gaps [$];
    logic        l_we = 1'b0;
    logic [31:0] l_adr = '0;
    logic [31:0] l_dat = '0;
    logic [3:0]  l_sel = '0;

    assign ack = slv_force |
                 (slv_en & cyc & stb & (wcnt == slv_wait));
    assign dat_i = slv_mem[rd_idx[2:0]];

    always @(posedge clk) begin
        if (slv_rst) begin
            wcnt     <= 0;
            rd_idx   <= 0;
            acks     <= 0;
            stb_cyc  <= 0;
            idle_run = 0;
            gaps.delete();
        end else begin
            if (cyc && stb) begin
                stb_cyc <= stb_cyc + 1;
                if (ack) begin
                    acks  <= acks + 1;
                    wcnt  <= 0;
                    l_we  <= we;
                    l_adr <= adr;
                    l_dat <= dat_o;
                    l_sel <= sel;
                    if (rd_idx < 7) rd_idx <= rd_idx + 1;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
            if (!cyc) begin
                idle_run++;
            end else if (idle_run > 0) begin
                gaps.push_back(idle_run);
                idle_run = 0;
            end
        end
    end

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  st;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   lat;

    task automatic prep(input logic en, input int w);
        slv_en   = en;
        slv_wait = w;
        slv_rst  = 1'b1;
        @(negedge clk);
        slv_rst  = 1'b0;
    endtask

    task automatic send(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] d,
        input logic [31:0] m,
        input logic [3:0]  s,
        input logic [31:0] edat,
        input logic [1:0]  est,
        output int         l
    );
        sb.push_back('{dat: edat, st: est});
        cmd_op    = op;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_mask  = m;
        cmd_sel   = s;
        cmd_valid = 1'b1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready got=%b want=1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        l = 1;
        while (rsp_valid !== 1'b1 && l < 300) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({cyc, stb, we, sel, adr, dat_o, rsp_valid, rsp_dat,
             rsp_status} !== '0) begin
            bad++;
            $display("FAIL reset_outs cyc=%b stb=%b rv=%b want all 0",
                     cyc, stb, rsp_valid);
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", cmd_ready);
        end
    endtask

    task automatic test_write();
        prep(1'b1, 2);
        send(OP_WRITE, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0, 4'hF,
             32'h0, ST_OK, lat);
        e = sb.pop_front();
        total++;
        if (rsp_valid !== 1'b1 || rsp_dat !== e.dat ||
            rsp_status !== e.st) begin
            bad++;
            $display("FAIL write_rsp got=%h/%b want=%h/%b",
                     rsp_dat, rsp_status, e.dat, e.st);
        end
        total++;
        if (acks !== 1 || stb_cyc !== 3) begin
            bad++;
            $display("FAIL write_bus acks=%0d stb=%0d want 1/3",
                     acks, stb_cyc);
        end
        total++;
        if (l_we !== 1'b1 || l_adr !== 32'h3000_0004 ||
            l_dat !== 32'hDEAD_BEEF || l_sel !== 4'hF) begin
            bad++;
            $display("FAIL write_fields we=%b adr=%h dat=%h sel=%h",
                     l_we, l_adr, l_dat, l_sel);
        end
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready got=%b want=0", cmd_ready);
        end
        take_rsp();
        total++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_hs ready=%b rv=%b want 1/0",
                     cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_read();
        slv_mem[0] = 32'h1234_5678;
        prep(1'b1, 0);
        send(OP_READ, 32'h3000_0010, 32'h0, 32'h0, 4'hF,
             32'h1234_5678, ST_OK, lat);
        e = sb.pop_front();
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL read_latency got=%0d want=2", lat);
        end
        total++;
        if (rsp_dat !== e.dat || rsp_status !== e.st || l_we !== 1'b0) begin
            bad++;
            $display("FAIL read_rsp got=%h/%b we=%b want=%h/%b",
                     rsp_dat, rsp_status, l_we, e.dat, e.st);
        end
        take_rsp();
    endtask

    task automatic test_poll();
        slv_mem[0] = 32'h0;
        slv_mem[1] = 32'h0;
        slv_mem[2] = 32'h0;
        slv_mem[3] = 32'h1;
        prep(1'b1, 0);
        send(OP_POLL, 32'h3000_0020, 32'h1, 32'h1, 4'hF,
             32'h1, ST_OK, lat);
        e = sb.pop_front();
        total++;
        if (rsp_dat !== e.dat || rsp_status !== e.st) begin
            bad++;
            $display("FAIL poll_rsp got=%h/%b want=%h/%b",
                     rsp_dat, rsp_status, e.dat, e.st);
        end
        total++;
        if (acks !== 4) begin
            bad++;
            $display("FAIL poll_acks got=%0d want=4", acks);
        end
        total++;
        if (gaps.size() != 4 || gaps[1] != PG || gaps[2] != PG ||
            gaps[3] != PG) begin
            bad++;
            $display("FAIL poll_gaps n=%0d want 4 with gaps of %0d",
                     gaps.size(), PG);
        end
        take_rsp();
    endtask

    task automatic test_exhaust();
        slv_mem[0] = 32'h2;
        slv_mem[1] = 32'h4;
        slv_mem[2] = 32'h6;
        slv_mem[3] = 32'h8;
        slv_mem[4] = 32'h1;
        prep(1'b1, 1);
        send(OP_POLL, 32'h3000_0020, 32'h1, 32'h1, 4'hF,
             32'h8, ST_EXHAUSTED, lat);
        e = sb.pop_front();
        total++;
        if (rsp_dat !== e.dat || rsp_status !== e.st) begin
            bad++;
            $display("FAIL exhaust_rsp got=%h/%b want=%h/%b",
                     rsp_dat, rsp_status, e.dat, e.st);
        end
        total++;
        if (acks !== PL) begin
            bad++;
            $display("FAIL exhaust_acks got=%0d want=%0d", acks, PL);
        end
        take_rsp();
    endtask

    task automatic test_mask0_and_reserved();
        slv_mem[0] = 32'hABCD_0000;
        prep(1'b1, 0);
        send(OP_POLL, 32'h3000_0024, 32'h5, 32'h0, 4'h3,
             32'hABCD_0000, ST_OK, lat);
        e = sb.pop_front();
        total++;
        if (rsp_dat !== e.dat || rsp_status !== e.st || acks !== 1) begin
            bad++;
            $display("FAIL mask0 got=%h/%b acks=%0d want=%h/%b/1",
                     rsp_dat, rsp_status, acks, e.dat, e.st);
        end
        take_rsp();
        slv_mem[0] = 32'h0000_55AA;
        prep(1'b1, 0);
        send(2'b11, 32'h3000_0028, 32'hFFFF_FFFF, 32'h0, 4'hF,
             32'h0000_55AA, ST_OK, lat);
        e = sb.pop_front();
        total++;
        if (rsp_dat !== e.dat || rsp_status !== e.st || l_we !== 1'b0) begin
            bad++;
            $display("FAIL reserved_op got=%h/%b we=%b want=%h/%b",
                     rsp_dat, rsp_status, l_we, e.dat, e.st);
        end
        take_rsp();
    endtask

    task automatic test_timeout();
        logic ok;
        prep(1'b0, 0);
        send(OP_READ, 32'h3000_0030, 32'h0, 32'h0, 4'hF,
             32'h0, ST_TIMEOUT, lat);
        e = sb.pop_front();
        total++;
        if (rsp_dat !== e.dat || rsp_status !== e.st) begin
            bad++;
            $display("FAIL tmo_rsp got=%h/%b want=%h/%b",
                     rsp_dat, rsp_status, e.dat, e.st);
        end
        total++;
        if (stb_cyc !== AT || lat !== AT + 1) begin
            bad++;
            $display("FAIL tmo_timing stb=%0d lat=%0d want %0d/%0d",
                     stb_cyc, lat, AT, AT + 1);
        end
        ok = 1'b1;
        slv_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_status !== ST_TIMEOUT ||
                rsp_dat !== 32'h0) ok = 1'b0;
        end
        take_rsp();
        repeat (3) begin
            @(negedge clk);
            if (cyc !== 1'b0 || rsp_valid !== 1'b0) ok = 1'b0;
        end
        slv_force = 1'b0;
        total++;
        if (ok !== 1'b1 || stb_cyc !== AT || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL late_ack ok=%b stb=%0d ready=%b want 1/%0d/1",
                     ok, stb_cyc, cmd_ready, AT);
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        slv_mem[0] = 32'h0BAD_F00D;
        prep(1'b1, 0);
        send(OP_READ, 32'h3000_0040, 32'h0, 32'h0, 4'hF,
             32'h0BAD_F00D, ST_OK, lat);
        cmd_op    = OP_WRITE;
        cmd_adr   = 32'h3000_0044;
        cmd_valid = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0BAD_F00D ||
                rsp_status !== ST_OK || cmd_ready !== 1'b0 ||
                cyc !== 1'b0) ok = 1'b0;
        end
        cmd_valid = 1'b0;
        total++;
        if (ok !== 1'b1 || acks !== 1) begin
            bad++;
            $display("FAIL backpressure ok=%b acks=%0d want 1/1", ok, acks);
        end
        e = sb.pop_front();
        total++;
        if (rsp_dat !== e.dat || rsp_status !== e.st) begin
            bad++;
            $display("FAIL bp_rsp got=%h/%b want=%h/%b",
                     rsp_dat, rsp_status, e.dat, e.st);
        end
        take_rsp();
    endtask

    task automatic test_reset_mid();
        logic ok;
        prep(1'b0, 0);
        cmd_op    = OP_READ;
        cmd_adr   = 32'h3000_0050;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        total++;
        if (cyc !== 1'b1 || stb !== 1'b1) begin
            bad++;
            $display("FAIL mid_req cyc=%b stb=%b want 1/1", cyc, stb);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (cyc !== 1'b0 || stb !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset cyc=%b stb=%b rv=%b want 0/0/0",
                     cyc, stb, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 ||
                cyc !== 1'b0) ok = 1'b0;
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL after_reset ready=%b rv=%b cyc=%b want 1/0/0",
                     cmd_ready, rsp_valid, cyc);
        end
    endtask

    task automatic test_back_to_back();
        slv_mem[0] = 32'hC0DE_0001;
        prep(1'b1, 0);
        send(OP_READ, 32'h3000_0060, 32'h0, 32'h0, 4'hF,
             32'hC0DE_0001, ST_OK, lat);
        e = sb.pop_front();
        total++;
        if (rsp_dat !== e.dat || rsp_status !== e.st || lat !== 2) begin
            bad++;
            $display("FAIL recover_rsp got=%h/%b lat=%0d want=%h/%b/2",
                     rsp_dat, rsp_status, lat, e.dat, e.st);
        end
        take_rsp();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) slv_mem[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_write();
        test_read();
        test_poll();
        test_exhaust();
        test_mask0_and_reserved();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
